// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Arbiter state, read-return owner tag and row geometry.
package dmem_arb_pkg;

    localparam int ROW_BYTES  = 16;
    localparam int WORD_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CORE,
        ST_GEMM
    } arb_state_e;

    typedef enum logic {
        OWN_CORE,
        OWN_GEMM
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] lane;
    } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, GEMM and memory-side signals of the arbiter.
// master = requesters plus memory, slave = the arbiter.
interface dmem_port_arbiter_if;

    logic         core_en;
    logic         core_rdwr;
    logic [3:0]   core_mask;
    logic [31:0]  core_addr;
    logic [31:0]  core_wr_data;
    logic         core_stall;
    logic         core_rd_valid;
    logic [31:0]  core_rd_data;

    logic         gemm_en;
    logic         gemm_rdwr;
    logic [4:0]   gemm_control;
    logic [31:0]  gemm_addr;
    logic [127:0] gemm_wr_data;
    logic         gemm_ready;
    logic         gemm_rd_valid;
    logic [127:0] gemm_rd_data;

    logic         mem_en;
    logic         mem_rdwr;
    logic [15:0]  mem_mask;
    logic [4:0]   mem_control;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wr_data;
    logic [127:0] mem_rd_data;

    modport master (
        output core_en, core_rdwr, core_mask,
        output core_addr, core_wr_data,
        input  core_stall, core_rd_valid, core_rd_data,
        output gemm_en, gemm_rdwr, gemm_control,
        output gemm_addr, gemm_wr_data,
        input  gemm_ready, gemm_rd_valid, gemm_rd_data,
        input  mem_en, mem_rdwr, mem_mask,
        input  mem_control, mem_addr, mem_wr_data,
        output mem_rd_data
    );

    modport slave (
        input  core_en, core_rdwr, core_mask,
        input  core_addr, core_wr_data,
        output core_stall, core_rd_valid, core_rd_data,
        input  gemm_en, gemm_rdwr, gemm_control,
        input  gemm_addr, gemm_wr_data,
        output gemm_ready, gemm_rd_valid, gemm_rd_data,
        output mem_en, mem_rdwr, mem_mask,
        output mem_control, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

endinterface

// File: rtl/dmem_port_arbiter_lane_align.sv
// Core-word lane steering into a 128-bit row.
// Mask/data placement for writes, word extract for reads.
module dmem_lane_align
    import dmem_arb_pkg::*;
(
    input  logic [1:0]             wr_lane,
    input  logic [3:0]             core_mask,
    input  logic [31:0]            core_wr_data,
    input  logic [1:0]             rd_lane,
    input  logic [8*ROW_BYTES-1:0] row_in,
    output logic [ROW_BYTES-1:0]   lane_mask,
    output logic [8*ROW_BYTES-1:0] lane_data,
    output logic [31:0]            rd_word
);

    assign lane_mask = ROW_BYTES'(core_mask) << {wr_lane, 2'b00};
    assign lane_data = {WORD_LANES{core_wr_data}};
    assign rd_word   = row_in[{rd_lane, 5'b0} +: 32];

endmodule

// File: rtl/dmem_port_arbiter.sv
// One-grant-per-cycle arbiter between the core and GEMM ports
// of a 128-bit row memory, with bounded GEMM bursts.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_GEMM_BURST = 8,
    parameter int CNT_W          = 4
) (
    input logic          clk,
    input logic          rst_n,
    dmem_port_arbiter_if.slave bus
);

    arb_state_e       state;
    logic [CNT_W-1:0] burst_cnt;
    rd_tag_t          tag;

    logic core_req;
    logic gemm_req;
    logic core_gnt;
    logic gemm_gnt;
    logic burst_full;

    logic [ROW_BYTES-1:0]   lane_mask;
    logic [8*ROW_BYTES-1:0] lane_data;
    logic [31:0]            rd_word;

    logic unused_addr;
    assign unused_addr = ^{bus.core_addr[1:0], bus.gemm_addr[3:0]};

    // Reset gates requests so every output is 0 while rst_n is low.
    assign core_req   = bus.core_en & rst_n;
    assign gemm_req   = bus.gemm_en & rst_n;
    assign burst_full = (burst_cnt == CNT_W'(MAX_GEMM_BURST));

    always_comb begin
        core_gnt = 1'b0;
        gemm_gnt = 1'b0;
        unique case (1'b1)
            (core_req && !gemm_req): core_gnt = 1'b1;
            (gemm_req && !core_req): gemm_gnt = 1'b1;
            (core_req && gemm_req): begin
                if (burst_full || state == ST_IDLE)
                    core_gnt = 1'b1;
                else
                    gemm_gnt = 1'b1;
            end
            default: ;
        endcase
    end

    dmem_lane_align u_align (
        .wr_lane      (bus.core_addr[3:2]),
        .core_mask    (bus.core_mask),
        .core_wr_data (bus.core_wr_data),
        .rd_lane      (tag.lane),
        .row_in       (bus.mem_rd_data),
        .lane_mask    (lane_mask),
        .lane_data    (lane_data),
        .rd_word      (rd_word)
    );

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_rdwr    = 1'b0;
        bus.mem_mask    = '0;
        bus.mem_control = '0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        if (core_gnt) begin
            bus.mem_en      = 1'b1;
            bus.mem_rdwr    = bus.core_rdwr;
            bus.mem_mask    = bus.core_rdwr ? lane_mask : '0;
            bus.mem_addr    = {bus.core_addr[31:4], 4'h0};
            bus.mem_wr_data = lane_data;
        end else if (gemm_gnt) begin
            bus.mem_en      = 1'b1;
            bus.mem_rdwr    = bus.gemm_rdwr;
            bus.mem_mask    = bus.gemm_rdwr ? 16'hFFFF : 16'h0;
            bus.mem_control = bus.gemm_control;
            bus.mem_addr    = {bus.gemm_addr[31:4], 4'h0};
            bus.mem_wr_data = bus.gemm_wr_data;
        end
    end

    assign bus.core_stall = core_req & ~core_gnt;
    assign bus.gemm_ready = gemm_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            tag       <= '0;
        end else begin
            unique case (1'b1)
                core_gnt: state <= ST_CORE;
                gemm_gnt: state <= ST_GEMM;
                default:  state <= ST_IDLE;
            endcase
            if (core_gnt || !bus.core_en)
                burst_cnt <= '0;
            else if (gemm_gnt && !burst_full)
                burst_cnt <= burst_cnt + CNT_W'(1);
            tag.valid <= core_gnt ? !bus.core_rdwr
                       : gemm_gnt ? !bus.gemm_rdwr
                       : 1'b0;
            tag.owner <= gemm_gnt ? OWN_GEMM : OWN_CORE;
            tag.lane  <= bus.core_addr[3:2];
        end
    end

    assign bus.core_rd_valid = tag.valid && tag.owner == OWN_CORE;
    assign bus.gemm_rd_valid = tag.valid && tag.owner == OWN_GEMM;
    assign bus.core_rd_data  = bus.core_rd_valid ? rd_word : '0;
    assign bus.gemm_rd_data  = bus.gemm_rd_valid ? bus.mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table,
// hand-written corner sequences and a randomized model run.
module tb_dmem_port_arbiter;

    localparam int MAX = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(
        .MAX_GEMM_BURST(MAX),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] row_init(input int i);
        logic [127:0] r;
        for (int w = 0; w < 4; w++)
            r[32*w +: 32] = 32'hC0DE_0000 + 32'(i * 16 + w);
        return r;
    endfunction

    function automatic logic [127:0] merged(input logic [127:0] old,
                                            input logic [127:0] nw,
                                            input logic [15:0] m);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++)
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural row memory with one-cycle read latency.
    bit           mem_init;
    logic [127:0] mem [256];
    logic [127:0] rd_q;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= row_init(i);
            mem_init <= 1'b1;
            rd_q <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_rdwr)
                mem[bus.mem_addr[11:4]] <= merged(mem[bus.mem_addr[11:4]],
                                                  bus.mem_wr_data, bus.mem_mask);
            else
                rd_q <= mem[bus.mem_addr[11:4]];
        end
    end
    assign bus.mem_rd_data = rd_q;

    task automatic set_idle();
        bus.core_en = 0; bus.core_rdwr = 0; bus.core_mask = 0;
        bus.core_addr = 0; bus.core_wr_data = 0;
        bus.gemm_en = 0; bus.gemm_rdwr = 0; bus.gemm_control = 0;
        bus.gemm_addr = 0; bus.gemm_wr_data = 0;
    endtask

    task automatic drv_core(input logic w, input logic [3:0] m,
                            input logic [31:0] a, input logic [31:0] d);
        bus.core_en = 1; bus.core_rdwr = w; bus.core_mask = m;
        bus.core_addr = a; bus.core_wr_data = d;
    endtask

    task automatic drv_gemm(input logic w, input logic [4:0] c,
                            input logic [31:0] a, input logic [127:0] d);
        bus.gemm_en = 1; bus.gemm_rdwr = w; bus.gemm_control = c;
        bus.gemm_addr = a; bus.gemm_wr_data = d;
    endtask

    typedef struct {
        logic ce; logic cw; logic [3:0] cm; logic [31:0] ca; logic [31:0] cd;
        logic ge; logic gw; logic [4:0] gc; logic [31:0] ga; logic [127:0] gd;
        logic x_stall; logic x_ready; logic x_en; logic x_rdwr;
        logic [15:0] x_mask; logic [4:0] x_ctrl; logic [31:0] x_addr;
        logic [127:0] x_wd;
        logic n_crv; logic n_grv; logic [31:0] n_cdata;
    } vec_t;

    vec_t vt [8];

    initial begin
        int last;
        int wait_n;
        bit pc_v, pg_v;
        logic [31:0] pc_d;
        logic [127:0] pg_d, row;
        logic ce, cw, ge, gw, cwin, gwin;
        logic [1:0] ln;
        logic [15:0] xm;
        bit cg;

        set_idle();
        rst_n = 1'b0;
        bus.core_en = 1; bus.gemm_en = 1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_stall", bus.core_stall, 0);
        chk("rst_ready", bus.gemm_ready, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_mask", bus.mem_mask, 0);
        chk("rst_crv", bus.core_rd_valid, 0);
        chk("rst_grv", bus.gemm_rd_valid, 0);
        set_idle();
        @(negedge clk); rst_n = 1'b1;

        vt[0] = '{1,1,4'hF,32'h14,32'hDEADBEEF, 0,0,0,0,0,
                  0,0,1,1,16'h00F0,0,32'h10,{4{32'hDEADBEEF}}, 0,0,0};
        vt[1] = '{1,1,4'h3,32'h08,32'h12345678, 0,0,0,0,0,
                  0,0,1,1,16'h0300,0,32'h0,{4{32'h12345678}}, 0,0,0};
        vt[2] = '{1,1,4'h8,32'h3F,32'hCAFEF00D, 0,0,0,0,0,
                  0,0,1,1,16'h8000,0,32'h30,{4{32'hCAFEF00D}}, 0,0,0};
        vt[3] = '{1,0,4'hF,32'h17,32'h0, 0,0,0,0,0,
                  0,0,1,0,16'h0,0,32'h10,0, 1,0,32'hDEADBEEF};
        vt[4] = '{0,0,0,0,0, 1,1,5'h15,32'h200,128'h0123456789ABCDEF_FEDCBA9876543210,
                  0,1,1,1,16'hFFFF,5'h15,32'h200,
                  128'h0123456789ABCDEF_FEDCBA9876543210, 0,0,0};
        vt[5] = '{0,0,0,0,0, 1,0,5'h03,32'h10C,0,
                  0,1,1,0,16'h0,5'h03,32'h100,0, 0,1,0};
        vt[6] = '{1,1,4'h1,32'h24,32'hA5A5A5A5, 1,0,5'h1F,32'h300,0,
                  0,0,1,1,16'h0010,0,32'h20,{4{32'hA5A5A5A5}}, 0,0,0};
        vt[7] = '{0,0,0,0,0, 0,0,0,0,0,
                  0,0,0,0,16'h0,0,32'h0,0, 0,0,0};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_idle();
            if (vt[i].ce) drv_core(vt[i].cw, vt[i].cm, vt[i].ca, vt[i].cd);
            if (vt[i].ge) drv_gemm(vt[i].gw, vt[i].gc, vt[i].ga, vt[i].gd);
            #1;
            chk($sformatf("v%0d_stall", i), bus.core_stall, vt[i].x_stall);
            chk($sformatf("v%0d_ready", i), bus.gemm_ready, vt[i].x_ready);
            chk($sformatf("v%0d_en", i), bus.mem_en, vt[i].x_en);
            chk($sformatf("v%0d_rdwr", i), bus.mem_rdwr, vt[i].x_rdwr);
            chk($sformatf("v%0d_mask", i), bus.mem_mask, vt[i].x_mask);
            chk($sformatf("v%0d_ctrl", i), bus.mem_control, vt[i].x_ctrl);
            chk($sformatf("v%0d_addr", i), bus.mem_addr, vt[i].x_addr);
            if (vt[i].x_en && vt[i].x_rdwr)
                chk($sformatf("v%0d_wdata", i), bus.mem_wr_data, vt[i].x_wd);
            @(negedge clk);
            set_idle();
            #1;
            chk($sformatf("v%0d_crv", i), bus.core_rd_valid, vt[i].n_crv);
            chk($sformatf("v%0d_grv", i), bus.gemm_rd_valid, vt[i].n_grv);
            if (vt[i].n_crv)
                chk($sformatf("v%0d_cdata", i), bus.core_rd_data, vt[i].n_cdata);
        end

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_idle();
            if (k < 4) drv_gemm(0, 0, 32'h100 + 32'(16 * k), 0);
            #1;
            chk("burst_ready", bus.gemm_ready, k < 4);
            chk("burst_grv", bus.gemm_rd_valid, k > 0);
            chk("burst_crv", bus.core_rd_valid, 0);
            if (k > 0) chk("burst_row", bus.gemm_rd_data, row_init(16 + k - 1));
        end

        @(negedge clk); set_idle(); drv_core(0, 4'hF, 32'h14, 0); #1;
        chk("mix_c_stall", bus.core_stall, 0);
        @(negedge clk); set_idle(); drv_gemm(0, 0, 32'h110, 0); #1;
        chk("mix_g_ready", bus.gemm_ready, 1);
        chk("mix1_crv", bus.core_rd_valid, 1);
        chk("mix1_grv", bus.gemm_rd_valid, 0);
        chk("mix1_cdata", bus.core_rd_data, 32'hDEADBEEF);
        @(negedge clk); set_idle(); #1;
        chk("mix2_crv", bus.core_rd_valid, 0);
        chk("mix2_grv", bus.gemm_rd_valid, 1);
        chk("mix2_row", bus.gemm_rd_data, row_init(17));

        @(negedge clk); set_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drv_core(1, 4'hF, 32'h40, 32'(c));
            drv_gemm(0, 0, 32'h100, 0);
            #1;
            cg = (c == 0 || c == 9);
            chk($sformatf("alt%0d_stall", c), bus.core_stall, !cg);
            chk($sformatf("alt%0d_ready", c), bus.gemm_ready, !cg);
        end

        @(negedge clk); set_idle(); drv_gemm(0, 0, 32'h100, 0); #1;
        chk("cont_warm_ready", bus.gemm_ready, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drv_core(0, 4'hF, 32'h14, 0);
            drv_gemm(0, 0, 32'h100, 0);
            #1;
            cg = (c == 8 || c == 17);
            chk($sformatf("cont%0d_stall", c), bus.core_stall, !cg);
            chk($sformatf("cont%0d_ready", c), bus.gemm_ready, !cg);
            chk($sformatf("cont%0d_crv", c), bus.core_rd_valid, c == 9 || c == 18);
            if (c == 9 || c == 18)
                chk($sformatf("cont%0d_cdata", c), bus.core_rd_data, 32'hDEADBEEF);
            if (cg) chk($sformatf("cont%0d_addr", c), bus.mem_addr, 32'h10);
        end

        @(negedge clk); set_idle(); drv_gemm(0, 5'h7, 32'h120, 0); #1;
        chk("rmid_ready", bus.gemm_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.core_en = 1;
        #1;
        chk("rmid_ready0", bus.gemm_ready, 0);
        chk("rmid_stall0", bus.core_stall, 0);
        chk("rmid_en0", bus.mem_en, 0);
        chk("rmid_ctrl0", bus.mem_control, 0);
        chk("rmid_addr0", bus.mem_addr, 0);
        chk("rmid_grv0", bus.gemm_rd_valid, 0);
        chk("rmid_gdata0", bus.gemm_rd_data, 0);
        @(negedge clk); #1;
        chk("rmid_grv1", bus.gemm_rd_valid, 0);
        @(negedge clk); set_idle(); rst_n = 1'b1; #1;
        chk("rmid_grv2", bus.gemm_rd_valid, 0);
        @(negedge clk); #1;
        chk("rmid_grv3", bus.gemm_rd_valid, 0);
        chk("rmid_crv3", bus.core_rd_valid, 0);

        last = 0; wait_n = 0; pc_v = 0; pg_v = 0; pc_d = 0; pg_d = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            set_idle();
            ce = ($urandom_range(0, 3) != 0);
            ge = ($urandom_range(0, 4) != 0);
            cw = $urandom_range(0, 1) == 1;
            gw = $urandom_range(0, 2) == 0;
            bus.core_en = ce; bus.core_rdwr = cw;
            bus.core_mask = 4'($urandom); bus.core_addr = $urandom;
            bus.core_wr_data = $urandom;
            bus.gemm_en = ge; bus.gemm_rdwr = gw;
            bus.gemm_control = 5'($urandom); bus.gemm_addr = $urandom;
            bus.gemm_wr_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            cwin = ce && (!ge || wait_n >= MAX || last == 0);
            gwin = ge && !cwin;
            ln = bus.core_addr[3:2];
            xm = 0;
            if (cwin && cw) xm = 16'(int'(bus.core_mask) * (1 << (4 * int'(ln))));
            if (gwin && gw) xm = 16'hFFFF;
            chk("rnd_stall", bus.core_stall, ce && !cwin);
            chk("rnd_ready", bus.gemm_ready, gwin);
            chk("rnd_en", bus.mem_en, cwin || gwin);
            chk("rnd_mask", bus.mem_mask, xm);
            chk("rnd_ctrl", bus.mem_control, gwin ? bus.gemm_control : 5'h0);
            if (cwin) begin
                chk("rnd_rdwr", bus.mem_rdwr, cw);
                chk("rnd_addr", bus.mem_addr, bus.core_addr & ~32'hF);
                if (cw)
                    for (int w = 0; w < 4; w++)
                        chk("rnd_cwdata", bus.mem_wr_data[32*w +: 32],
                            bus.core_wr_data);
            end
            if (gwin) begin
                chk("rnd_rdwr", bus.mem_rdwr, gw);
                chk("rnd_addr", bus.mem_addr, bus.gemm_addr & ~32'hF);
                if (gw) chk("rnd_gwdata", bus.mem_wr_data, bus.gemm_wr_data);
            end
            chk("rnd_crv", bus.core_rd_valid, pc_v);
            chk("rnd_grv", bus.gemm_rd_valid, pg_v);
            if (pc_v) chk("rnd_cdata", bus.core_rd_data, pc_d);
            if (pg_v) chk("rnd_gdata", bus.gemm_rd_data, pg_d);
            pc_v = cwin && !cw;
            pg_v = gwin && !gw;
            row = mem[bus.core_addr[11:4]];
            pc_d = row[32*ln +: 32];
            pg_d = mem[bus.gemm_addr[11:4]];
            last = cwin ? 1 : (gwin ? 2 : 0);
            wait_n = (ce && !cwin) ? wait_n + 1 : 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
